// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with sub-word access, sign/zero extension,
// a fixed-latency load pipeline and alignment/range error reporting.
module data_memory_sized #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic [63:0]       address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              err
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  // word 0 lives apart so it can carry a power-up value
  logic [DATA_W-1:0] word0 = '0;

  logic [LW-1:0]     lane;
  logic [IW-1:0]     idx;
  logic [7:0]        nb_req;
  logic [7:0]        lane8;
  logic [10:0]       nbits;
  logic              oor;
  logic              misal;
  logic              oversz;
  logic              fault;
  logic              wr_ok;
  logic              rd_req;
  logic              sign;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;

  logic [READ_LAT-1:0] p_vld;
  logic [READ_LAT-1:0] p_err;
  logic [DATA_W-1:0]   p_dat [READ_LAT];
  logic                st_err;

  assign lane   = address[LW-1:0];
  assign idx    = address[LW +: IW];
  assign oor    = |address[63:LW+IW];
  assign nb_req = 8'd1 << size;
  assign nbits  = {nb_req, 3'b000};
  assign lane8  = 8'(lane);
  assign misal  = |(lane8 & (nb_req - 8'd1));
  assign oversz = nb_req > 8'(NB);
  assign fault  = misal | oversz | oor;
  assign wr_ok  = En & memWrite & ~fault;
  assign rd_req = En & memRead;

  assign cur     = (idx == '0) ? word0 : mem[idx];
  assign wsh     = write_data << {lane, 3'b000};
  assign rd_word = wr_ok ? merged : cur;
  assign sh      = rd_word >> {lane, 3'b000};

  always_comb begin
    merged = cur;
    for (int b = 0; b < NB; b++) begin
      if (8'(b) >= lane8 && 8'(b) < lane8 + nb_req)
        merged[b*8 +: 8] = wsh[b*8 +: 8];
    end
  end

  always_comb begin
    sign = 1'b0;
    unique case (size)
      2'd0: sign = sh[7];
      2'd1: sign = sh[15];
      2'd2: sign = sh[31];
      2'd3: sign = sh[DATA_W-1];
    endcase
    ext = sh;
    for (int b = 0; b < DATA_W; b++) begin
      if (11'(b) >= nbits)
        ext[b] = ~ld_unsigned & sign;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      if (idx == '0) word0 <= merged;
      else           mem[idx] <= merged;
    end
  end

  // data stages only advance behind a valid so the tail holds the last load
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      p_vld  <= '0;
      p_err  <= '0;
      st_err <= 1'b0;
      for (int i = 0; i < READ_LAT; i++)
        p_dat[i] <= '0;
    end else begin
      p_vld[0] <= rd_req;
      p_err[0] <= rd_req & fault;
      st_err   <= En & memWrite & fault;
      if (rd_req)
        p_dat[0] <= fault ? '0 : ext;
      for (int i = 1; i < READ_LAT; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_err[i] <= p_err[i-1];
        if (p_vld[i-1])
          p_dat[i] <= p_dat[i-1];
      end
    end
  end

  assign read_valid = p_vld[READ_LAT-1];
  assign read_data  = p_dat[READ_LAT-1];
  assign err        = (p_vld[READ_LAT-1] & p_err[READ_LAT-1]) | st_err;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: latency-1 and latency-3 instances
// share stimulus; separate monitors pop expected loads on read_valid.
module tb_data_memory_sized;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        rst1, rst3;
  logic        en, rd, wr, uns;
  logic [63:0] addr, wdata;
  logic [1:0]  sz;
  logic [63:0] rdata1, rdata3;
  logic        rv1, rv3, err1, err3;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 1'b0;
  exp_t q1[$];
  exp_t q3[$];
  int   stq1[$];
  int   stq3[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  data_memory_sized #(.DATA_W(64), .DEPTH(64), .READ_LAT(1)) u1 (
    .Clk(Clk), .Rst_n(rst1), .En(en), .address(addr),
    .write_data(wdata), .memRead(rd), .memWrite(wr), .size(sz),
    .ld_unsigned(uns), .read_data(rdata1), .read_valid(rv1), .err(err1)
  );

  data_memory_sized #(.DATA_W(64), .DEPTH(64), .READ_LAT(3)) u3 (
    .Clk(Clk), .Rst_n(rst3), .En(en), .address(addr),
    .write_data(wdata), .memRead(rd), .memWrite(wr), .size(sz),
    .ld_unsigned(uns), .read_data(rdata3), .read_valid(rv3), .err(err3)
  );

  task automatic chk(input string name, input bit ok,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon(input string tag, input bit rv, input bit e,
                     input logic [63:0] d, inout exp_t q[$], inout int sq[$]);
    bit   exp_st;
    exp_t x;
    exp_st = 1'b0;
    if (sq.size() > 0 && sq[0] == cyc) begin
      exp_st = 1'b1;
      void'(sq.pop_front());
    end
    if (rv) begin
      if (q.size() == 0) begin
        chk({tag, " unexpected read_valid"}, 1'b0, d, 64'h0);
      end else begin
        x = q.pop_front();
        chk({tag, " load data"}, d == x.data, d, x.data);
        chk({tag, " load err"}, e == (x.err | exp_st),
            64'(e), 64'(x.err | exp_st));
        chk({tag, " load cycle"}, cyc == x.cyc, 64'(cyc), 64'(x.cyc));
      end
    end else if (e || exp_st) begin
      chk({tag, " store err"}, e == exp_st, 64'(e), 64'(exp_st));
    end
  endtask

  always @(negedge Clk) begin
    if (mon_on) begin
      mon("lat1", rv1, err1, rdata1, q1, stq1);
      mon("lat3", rv3, err3, rdata3, q3, stq3);
    end
  end

  task automatic idle(input bit r3);
    @(posedge Clk);
    #1;
    en   = 1'b0;
    rd   = 1'b0;
    wr   = 1'b0;
    rst3 = r3;
  endtask

  task automatic req(input bit r, input bit w, input logic [63:0] a,
                     input logic [63:0] d, input logic [1:0] s, input bit u,
                     input logic [63:0] xd, input bit xe,
                     input bit r3, input bit push3);
    exp_t x;
    @(posedge Clk);
    #1;
    en    = 1'b1;
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    sz    = s;
    uns   = u;
    rst3  = r3;
    if (r) begin
      x.data = xd;
      x.err  = xe;
      x.cyc  = cyc + 1;
      q1.push_back(x);
      if (push3) begin
        x.cyc = cyc + 3;
        q3.push_back(x);
      end
    end
    if (w && xe) begin
      stq1.push_back(cyc + 1);
      if (push3) stq3.push_back(cyc + 1);
    end
  endtask

  initial begin
    rst1 = 1'b0; rst3 = 1'b0;
    en = 1'b0; rd = 1'b0; wr = 1'b0; uns = 1'b0;
    addr = '0; wdata = '0; sz = 2'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset rdata1", rdata1 == 64'h0, rdata1, 64'h0);
    chk("reset rv1", rv1 == 1'b0, 64'(rv1), 64'h0);
    chk("reset err1", err1 == 1'b0, 64'(err1), 64'h0);
    chk("reset rdata3", rdata3 == 64'h0, rdata3, 64'h0);
    chk("reset rv3", rv3 == 1'b0, 64'(rv3), 64'h0);
    chk("reset err3", err3 == 1'b0, 64'(err3), 64'h0);
    rst1 = 1'b1; rst3 = 1'b1;
    mon_on = 1'b1;

    // double store/load
    req(0, 1, 64'h10, 64'h1122334455667788, 2'd3, 0, 0, 0, 1, 1);
    req(1, 0, 64'h10, 0, 2'd3, 0, 64'h1122334455667788, 0, 1, 1);
    // sign/zero extension
    req(0, 1, 64'h18, 64'h80F0, 2'd3, 0, 0, 0, 1, 1);
    req(1, 0, 64'h18, 0, 2'd0, 0, 64'hFFFFFFFFFFFFFFF0, 0, 1, 1);
    req(1, 0, 64'h18, 0, 2'd1, 1, 64'h00000000000080F0, 0, 1, 1);
    req(1, 0, 64'h18, 0, 2'd1, 0, 64'hFFFFFFFFFFFF80F0, 0, 1, 1);
    // partial store, then load on the very next cycle
    req(0, 1, 64'h20, 64'hFFFFFFFFFFFFFFFF, 2'd3, 0, 0, 0, 1, 1);
    req(0, 1, 64'h23, 64'hAB, 2'd0, 0, 0, 0, 1, 1);
    req(1, 0, 64'h20, 0, 2'd3, 0, 64'hFFFFFFFFABFFFFFF, 0, 1, 1);
    req(1, 0, 64'h24, 0, 2'd2, 1, 64'h00000000FFFFFFFF, 0, 1, 1);
    req(1, 0, 64'h20, 0, 2'd2, 0, 64'hFFFFFFFFABFFFFFF, 0, 1, 1);
    req(1, 0, 64'h23, 0, 2'd0, 1, 64'h00000000000000AB, 0, 1, 1);
    // faults
    req(0, 1, 64'h21, 64'h1234, 2'd1, 0, 0, 1, 1, 1);
    idle(1);
    req(1, 0, 64'h20, 0, 2'd3, 0, 64'hFFFFFFFFABFFFFFF, 0, 1, 1);
    req(1, 0, 64'h200, 0, 2'd3, 0, 64'h0, 1, 1, 1);
    req(1, 0, 64'h23, 0, 2'd1, 0, 64'h0, 1, 1, 1);
    idle(1);
    // write-first
    req(1, 1, 64'h08, 64'h5A, 2'd3, 0, 64'h5A, 0, 1, 1);
    idle(1);
    // back-to-back loads of words 0..3
    req(1, 0, 64'h00, 0, 2'd3, 0, 64'h0, 0, 1, 1);
    req(1, 0, 64'h08, 0, 2'd3, 0, 64'h5A, 0, 1, 1);
    req(1, 0, 64'h10, 0, 2'd3, 0, 64'h1122334455667788, 0, 1, 1);
    req(1, 0, 64'h18, 0, 2'd3, 0, 64'h80F0, 0, 1, 1);
    repeat (5) idle(1);
    // reset flushes in-flight loads of the latency-3 instance
    req(1, 0, 64'h10, 0, 2'd3, 0, 64'h1122334455667788, 0, 1, 0);
    req(1, 0, 64'h18, 0, 2'd3, 0, 64'h80F0, 0, 0, 0);
    idle(1);
    repeat (5) idle(1);
    @(negedge Clk);
    chk("post-reset rdata3", rdata3 == 64'h0, rdata3, 64'h0);
    chk("post-reset rv3", rv3 == 1'b0, 64'(rv3), 64'h0);
    chk("post-reset err3", err3 == 1'b0, 64'(err3), 64'h0);
    chk("lat1 queue drained", q1.size() == 0 && stq1.size() == 0,
        64'(q1.size() + stq1.size()), 64'h0);
    chk("lat3 queue drained", q3.size() == 0 && stq3.size() == 0,
        64'(q3.size() + stq3.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the single-cycle 64-bit data memory in the datapath's MEM stage.
- Adds byte-addressed sub-word loads and stores (byte, half, word, double) with sign/zero extension.
- Adds a configurable read-latency pipeline with a valid strobe, plus alignment and range error reporting.
- The CPU issues one request per cycle; load results return READ_LAT cycles later.

Parameters:
- DATA_W, 64, word width in bits; legal values 32 or 64. NB = DATA_W/8 bytes per word.
- DEPTH, 64, number of words; power of two, at least 2.
- READ_LAT, 1, read latency in cycles, from request to read_valid; legal values 1 to 4.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous active-low reset.
- En  input  1  request qualifier; no access occurs when low.
- address  input  64  byte address.
- write_data  input  DATA_W  store data; operand is in the low bytes.
- memRead  input  1  load request.
- memWrite  input  1  store request.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
- ld_unsigned  input  1  1 = zero-extend load; 0 = sign-extend load.
- read_data  output  DATA_W  extended load result.
- read_valid  output  1  read_data valid this cycle (one-cycle pulse per load).
- err  output  1  error pulse for a faulting request.

Behaviour:
- Interface fixed: one clock, Clk; reset Rst_n is synchronous and active-low.
- Reset (Rst_n low at a posedge):
  - read_data = 0, read_valid = 0, err = 0.
  - The read pipeline is flushed; in-flight loads are dropped and never produce read_valid.
  - Memory contents are not cleared. Word 0 is initialised to 0 at time zero.
- Address decode:
  - lane = address[log2(NB)-1:0].
  - index = address[log2(NB) +: log2(DEPTH)].
  - out_of_range if any address bit above index is 1.
- Fault conditions (any one makes the request faulting):
  - misaligned: lane is not a multiple of (1<<size).
  - oversize: (1<<size) > NB, e.g. size 11 with DATA_W = 32.
  - out_of_range, as decoded above.
- Faulting store: memory is unchanged; err pulses on the next cycle.
- Faulting load: the request still completes. read_valid pulses after READ_LAT cycles with read_data = 0, and err pulses in that same cycle.
- Store (En & memWrite, not faulting):
  - At the posedge, bytes lane .. lane+(1<<size)-1 of word index take write_data bytes 0 .. (1<<size)-1.
  - All other bytes of the word are untouched.
- Load (En & memRead, not faulting):
  - The word is read at the request posedge.
  - Bytes lane .. lane+(1<<size)-1 are shifted to the LSB.
  - The result is zero-extended if ld_unsigned, otherwise sign-extended from its top bit.
  - It passes through READ_LAT-1 further register stages. read_data and read_valid appear exactly READ_LAT cycles after the request edge (READ_LAT = 1 means the next cycle).
- Simultaneous memRead and memWrite on the same request: write-first. The store is applied before the read, so the load returns the newly written bytes.
- A load issued one cycle after a store to the same word returns the updated data.
- Back-to-back loads are accepted every cycle. Results return in order, one read_valid per load; the pipeline has no stall.
- En low, or neither memRead nor memWrite: no access and no err. A bubble enters the pipeline.
- read_data holds its last valid value while read_valid is 0; it returns to 0 only on reset.
- err for a faulting load is aligned with that load's read_valid. err for a faulting store is one cycle after the request. If both fall in the same cycle, err is the OR of the two.

Test Plan:
- Double store/load, READ_LAT=1:
  - Store size 11 at address 0x10, data 0x1122334455667788.
  - Load size 11 at address 0x10 -> next cycle read_valid=1, read_data=0x1122334455667788, err=0.
- Sub-word sign/zero extension:
  - Preload word at 0x18 with 0x00000000000080F0.
  - Signed byte load at address 0x18 -> 0xFFFFFFFFFFFFFFF0.
  - Unsigned half load at address 0x18 -> 0x00000000000080F0.
  - Signed half load at address 0x18 -> 0xFFFFFFFFFFFF80F0.
- Partial store:
  - Word at 0x20 = 0xFFFFFFFFFFFFFFFF; store byte 0xAB at address 0x23.
  - Reload double -> 0xFFFFFFFFABFFFFFF.
- Faults:
  - Half store at 0x21 -> err pulses the next cycle, memory unchanged.
  - Load at 64*8 = 0x200 (out of range) -> read_valid with read_data=0 and err=1.
- READ_LAT=3 pipeline:
  - Four back-to-back loads of words 0..3 -> read_valid high on cycles 3..6 with data in order.
  - Rst_n low on cycle 2 -> no read_valid afterwards; outputs 0.
- Write-first: En=1, memRead=1, memWrite=1 at 0x08 with data 0x5A -> read_data=0x5A (size 11).
